// File: rtl/digit_serial_adder_ctrl.sv
// Digit-serial WIDTH-bit add/subtract controller. A single 4-bit ripple slice is reused
// once per nibble, LSB first, between an operand handshake and a result handshake.
module digit_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int DIGITS = WIDTH / 4;
    localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [4:0]       slice;

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;

        nib_a = '0;
        nib_b = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (cnt_q == CW'(k)) begin
                nib_a = op_a_q[4*k +: 4];
                nib_b = op_b_q[4*k +: 4];
            end
        end
        slice = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};

        case (state_q)
            S_IDLE: begin
                // Subtraction is a + ~b + 1, so sub forces the initial carry and cin is ignored.
                if (in_valid && in_ready_q) begin
                    op_a_d     = a;
                    op_b_d     = sub ? ~b : b;
                    carry_d    = sub | cin;
                    cnt_d      = '0;
                    sum_d      = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (cnt_q == CW'(k)) begin
                        sum_d[4*k +: 4] = slice[3:0];
                    end
                end
                carry_d = slice[4];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(DIGITS - 1)) begin
                    cout_d      = slice[4];
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_digit_serial_adder_ctrl.sv
// Directed bench for digit_serial_adder_ctrl at WIDTH=16: vector table of add/sub
// cases plus hand-written sequences for backpressure, reset and back-to-back traffic.
module tb_digit_serial_adder_ctrl;

    localparam int WIDTH  = 16;
    localparam int DIGITS = WIDTH / 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int passCount  = 0;
    int totalCount = 0;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        logic [WIDTH-1:0] expSum;
        logic             expCout;
    } vec_t;

    vec_t vecs[12];

    digit_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called at a negedge; returns just after the accept edge with the inputs scrambled.
    task automatic applyStimulus(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                 input logic vcin, input logic vsub);
        a        = va;
        b        = vb;
        cin      = vcin;
        sub      = vsub;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        if (!in_ready) begin
            checkOutput("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            a        = 16'hDEAD;
            b        = 16'hBEEF;
            cin      = ~vcin;
            sub      = ~vsub;
        end
    endtask

    // Observes 12 negedges after an accept edge with out_ready held high.
    task automatic collectResult(output logic [WIDTH-1:0] rSum, output logic rCout,
                                 output int latency, output int busyCnt, output int validCnt);
        rSum     = '0;
        rCout    = 1'b0;
        latency  = -1;
        busyCnt  = 0;
        validCnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) busyCnt++;
            if (out_valid) begin
                if (validCnt == 0) begin
                    rSum    = sum;
                    rCout   = cout;
                    latency = i;
                end
                validCnt++;
            end
        end
    endtask

    task automatic waitOutValid();
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    endtask

    logic [WIDTH-1:0] rSum;
    logic             rCout;
    int               latency, busyCnt, validCnt;
    int               cyc, nAcc, nRes, seenValid;
    int               accCyc[3];
    logic             accNow;
    logic [WIDTH-1:0] bbA[3], bbB[3], bbSum[3];
    logic             bbSub[3], bbCout[3];

    initial begin
        vecs[0]  = '{"add_basic",    16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0};
        vecs[1]  = '{"ripple_ones",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[2]  = '{"ripple_cin",   16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0};
        vecs[3]  = '{"sub_pos",      16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1};
        vecs[4]  = '{"sub_neg",      16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0};
        vecs[5]  = '{"sub_pos_cin",  16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1};
        vecs[6]  = '{"sub_neg_cin",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0};
        vecs[7]  = '{"add_max_cin",  16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1};
        vecs[8]  = '{"sub_zero",     16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1};
        vecs[9]  = '{"add_msb",      16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[10] = '{"add_0f0f",     16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0};
        vecs[11] = '{"sub_mid",      16'h1234, 16'h0234, 1'b0, 1'b1, 16'h1000, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_sum",       32'(sum),       32'd0);
        checkOutput("rst_cout",      32'(cout),      32'd0);
        checkOutput("rst_busy",      32'(busy),      32'd0);

        $display("[TB] vector table");
        for (int v = 0; v < 12; v++) begin
            applyStimulus(vecs[v].a, vecs[v].b, vecs[v].cin, vecs[v].sub);
            collectResult(rSum, rCout, latency, busyCnt, validCnt);
            checkOutput($sformatf("%s.sum", vecs[v].name),     32'(rSum),    32'(vecs[v].expSum));
            checkOutput($sformatf("%s.cout", vecs[v].name),    32'(rCout),   32'(vecs[v].expCout));
            checkOutput($sformatf("%s.latency", vecs[v].name), 32'(latency), 32'(DIGITS));
            checkOutput($sformatf("%s.busy", vecs[v].name),    32'(busyCnt), 32'(DIGITS + 1));
            checkOutput($sformatf("%s.pulses", vecs[v].name),  32'(validCnt), 32'd1);
        end

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
        waitOutValid();
        checkOutput("bp_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        a        = 16'h0F0F;
        b        = 16'h0101;
        cin      = 1'b0;
        sub      = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checkOutput("bp_sum",      32'(sum),       32'h5555);
            checkOutput("bp_cout",     32'(cout),      32'd0);
            checkOutput("bp_in_ready", 32'(in_ready),  32'd0);
            checkOutput("bp_hold",     32'(out_valid), 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_drop_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_idle_ready", 32'(in_ready),  32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        collectResult(rSum, rCout, latency, busyCnt, validCnt);
        checkOutput("bp_next_sum",     32'(rSum),    32'h1010);
        checkOutput("bp_next_cout",    32'(rCout),   32'd0);
        checkOutput("bp_next_latency", 32'(latency), 32'(DIGITS));

        $display("[TB] reset mid-run");
        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_rst_in_ready",  32'(in_ready),  32'd1);
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_sum",       32'(sum),       32'd0);
        checkOutput("mid_rst_cout",      32'(cout),      32'd0);
        checkOutput("mid_rst_busy",      32'(busy),      32'd0);
        seenValid = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seenValid++;
        end
        checkOutput("mid_rst_no_pulse", 32'(seenValid), 32'd0);
        applyStimulus(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        collectResult(rSum, rCout, latency, busyCnt, validCnt);
        checkOutput("post_rst_sum",  32'(rSum),  32'h1010);
        checkOutput("post_rst_cout", 32'(rCout), 32'd0);

        $display("[TB] reset in DONE");
        out_ready = 1'b0;
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        waitOutValid();
        checkOutput("done_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        checkOutput("done_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("done_rst_cout",      32'(cout),      32'd0);
        checkOutput("done_rst_in_ready",  32'(in_ready),  32'd1);

        $display("[TB] reset with in_valid");
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 16'h1111;
        b        = 16'h1111;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        checkOutput("rst_iv_busy",     32'(busy),     32'd0);
        checkOutput("rst_iv_in_ready", 32'(in_ready), 32'd1);
        seenValid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid || busy) seenValid++;
        end
        checkOutput("rst_iv_no_op", 32'(seenValid), 32'd0);

        $display("[TB] back-to-back");
        bbA[0] = 16'h1111; bbB[0] = 16'h2222; bbSub[0] = 1'b0; bbSum[0] = 16'h3333; bbCout[0] = 1'b0;
        bbA[1] = 16'hFFF0; bbB[1] = 16'h0010; bbSub[1] = 1'b0; bbSum[1] = 16'h0000; bbCout[1] = 1'b1;
        bbA[2] = 16'h8000; bbB[2] = 16'h0001; bbSub[2] = 1'b1; bbSum[2] = 16'h7FFF; bbCout[2] = 1'b1;
        out_ready = 1'b1;
        a         = bbA[0];
        b         = bbB[0];
        sub       = bbSub[0];
        cin       = 1'b0;
        in_valid  = 1'b1;
        cyc       = 0;
        nAcc      = 0;
        nRes      = 0;
        accCyc    = '{0, 0, 0};
        for (int c = 0; c < 60 && nRes < 3; c++) begin
            accNow = in_valid && in_ready;
            if (out_valid) begin
                checkOutput($sformatf("b2b%0d_sum", nRes),  32'(sum),  32'(bbSum[nRes]));
                checkOutput($sformatf("b2b%0d_cout", nRes), 32'(cout), 32'(bbCout[nRes]));
                nRes++;
            end
            @(posedge clk);
            cyc++;
            if (accNow && nAcc < 3) begin
                accCyc[nAcc] = cyc;
                nAcc++;
                #1;
                if (nAcc < 3) begin
                    a   = bbA[nAcc];
                    b   = bbB[nAcc];
                    sub = bbSub[nAcc];
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput("b2b_results", 32'(nRes), 32'd3);
        checkOutput("b2b_accepts", 32'(nAcc), 32'd3);
        checkOutput("b2b_gap01",   32'(accCyc[1] - accCyc[0]), 32'(DIGITS + 2));
        checkOutput("b2b_gap12",   32'(accCyc[2] - accCyc[1]), 32'(DIGITS + 2));

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
